mtm_alu_deserializer: RTL and testbench

MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

---
 rtl/mtm_alu_deserializer.sv | 86 ++++++++
 tb/tb_mtm_alu_deserializer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: receives 11-bit serial packets, assembles the A/B operands and
// releases a CRC-checked control word to the ALU core as a one-cycle strobe.
module mtm_alu_deserializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [7:0]  CTL_out,
  output logic        out_valid
);
  typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;
  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic        type_q;
  logic [7:0]  pay_q;
  logic [63:0] sr_q;
  logic [3:0]  cnt_q;
  logic        ferr_q;
  logic [31:0] a_q, b_q;
  logic [7:0]  ctl_q;
  logic        valid_q;
  logic [67:0] crc_vec;
  logic [3:0]  crc_d;
  assign crc_vec = {sr_q, 1'b1, pay_q[6:4]};
  always_comb begin
    crc_d = 4'h0;
    for (int i = 67; i >= 0; i--)
      crc_d = {crc_d[2:0], 1'b0} ^ ((crc_d[3] ^ crc_vec[i]) ? 4'h3 : 4'h0);
  end
  always_ff @(posedge clk) begin
    ctl_q   <= 8'hFF;
    valid_q <= 1'b0;
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      type_q    <= 1'b0;
      pay_q     <= 8'h00;
      sr_q      <= 64'h0;
      cnt_q     <= 4'd0;
      ferr_q    <= 1'b0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (!sin) state_q <= TYPE;
        TYPE: begin
          type_q  <= sin;
          state_q <= PAYLOAD;
        end
        PAYLOAD: begin
          pay_q     <= {pay_q[6:0], sin};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          // a broken stop bit poisons the frame until the next good command
          if (!sin) begin
            ferr_q <= 1'b1;
            if (type_q) cnt_q <= 4'd0;
          end else if (!type_q) begin
            sr_q <= {sr_q[55:0], pay_q};
            if (cnt_q != 4'd9) cnt_q <= cnt_q + 4'd1;
          end else begin
            cnt_q   <= 4'd0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b1;
            if (cnt_q != 4'd8 || ferr_q) ctl_q <= 8'hC9;
            else if (crc_d != pay_q[3:0]) ctl_q <= 8'hA5;
            else begin
              ctl_q <= {1'b0, pay_q[6:0]};
              b_q   <= sr_q[63:32];
              a_q   <= sr_q[31:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign A         = a_q;
  assign B         = b_q;
  assign CTL_out   = ctl_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed frame vectors plus reset and framing-error sequences.
module tb_mtm_alu_deserializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] A, B;
  logic [7:0]  CTL_out;
  logic        out_valid;
  int checks = 0, errors = 0, exp_pulses = 0;
  int pulses = 0, idle_errs = 0;
  logic mon_en = 1'b0;
  mtm_alu_deserializer dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .A(A), .B(B), .CTL_out(CTL_out), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  // outside the strobe cycle the control word must idle at FF
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) pulses++;
      else if (CTL_out !== 8'hFF) begin
        idle_errs++;
        $display("FAIL idle_ctl at %0t: got %h expected ff", $time, CTL_out);
      end
    end
  end
  typedef struct {
    logic [71:0] data;
    int          n;
    int          bad;
    logic        auto_crc;
    logic [7:0]  cmd;
    int          kind;
    logic [31:0] ea, eb;
  } vec_t;
  vec_t tv[9];
  function automatic logic [3:0] crc_ref(input logic [63:0] d, input logic [2:0] op);
    logic [71:0] m;
    m = {d, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
    return m[3:0];
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask
  task automatic send_pkt(input logic t, input logic [7:0] p, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(p[i]);
    send_bit(stop);
  endtask
  task automatic expect_result(input string nm, input logic [7:0] ectl,
                               input logic [31:0] ea, input logic [31:0] eb);
    exp_pulses++;
    @(negedge clk);
    sin = 1'b1;
    chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({nm, "_ctl"}, {24'b0, CTL_out}, {24'b0, ectl});
    chk({nm, "_A"}, A, ea);
    chk({nm, "_B"}, B, eb);
    @(negedge clk);
    chk({nm, "_pulse_end"}, {31'b0, out_valid}, 32'd0);
  endtask
  task automatic send_frame(input logic [63:0] d, input logic [2:0] op, input logic cstop);
    for (int i = 0; i < 8; i++) send_pkt(1'b0, d[8*(7-i) +: 8], 1'b1);
    send_pkt(1'b1, {1'b0, op, crc_ref(d, op)}, cstop);
  endtask
  initial begin
    logic [7:0] cmd, ectl;
    tv[0] = '{72'h0, 8, -1, 1'b0, 8'h0B, 0, 32'h0, 32'h0};
    tv[1] = '{72'h0, 8, -1, 1'b0, 8'h0A, 1, 32'h0, 32'h0};
    tv[2] = '{72'h0, 7, -1, 1'b0, 8'h0B, 2, 32'h0, 32'h0};
    tv[3] = '{72'h00_11223344_55667788, 8, -1, 1'b1, 8'h20, 0, 32'h55667788, 32'h11223344};
    tv[4] = '{72'h00_A1A2A3A4_A5A6A7A8, 8, 2, 1'b1, 8'h30, 2, 32'h55667788, 32'h11223344};
    tv[5] = '{72'h99_AABBCCDD_EEFF0011, 9, -1, 1'b1, 8'h50, 2, 32'h55667788, 32'h11223344};
    tv[6] = '{72'h0, 7, -1, 1'b0, 8'h0A, 2, 32'h55667788, 32'h11223344};
    tv[7] = '{72'h00_DEADBEEF_CAFEF00D, 8, -1, 1'b1, 8'h70, 0, 32'hCAFEF00D, 32'hDEADBEEF};
    tv[8] = '{72'h0, 8, -1, 1'b0, 8'h8B, 0, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    chk("rst_A", A, 32'h0);
    chk("rst_B", B, 32'h0);
    chk("rst_ctl", {24'b0, CTL_out}, 32'hFF);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < tv[v].n; i++)
        send_pkt(1'b0, tv[v].data[8*(tv[v].n-1-i) +: 8], i != tv[v].bad);
      cmd = tv[v].auto_crc ? {tv[v].cmd[7:4], crc_ref(tv[v].data[63:0], tv[v].cmd[6:4])} : tv[v].cmd;
      send_pkt(1'b1, cmd, 1'b1);
      ectl = tv[v].kind == 0 ? {1'b0, cmd[6:0]} : tv[v].kind == 1 ? 8'hA5 : 8'hC9;
      expect_result($sformatf("vec%0d", v), ectl, tv[v].ea, tv[v].eb);
    end
    // reset in the middle of data packet 5
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'h10 + 8'(i), 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_A", A, 32'h0);
    chk("midrst_B", B, 32'h0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    send_frame(64'h01020304_05060708, 3'b001, 1'b1);
    expect_result("after_rst", {4'b0001, crc_ref(64'h01020304_05060708, 3'b001)},
                  32'h05060708, 32'h01020304);
    // command packet with a broken stop bit: silent, and the next frame is rejected
    send_frame(64'h0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sin = 1'b1;
      chk("cmd_ferr_silent", {31'b0, out_valid}, 32'd0);
    end
    send_frame(64'h0, 3'b000, 1'b1);
    expect_result("ferr_carry", 8'hC9, 32'h05060708, 32'h01020304);
    send_frame(64'h0, 3'b000, 1'b1);
    expect_result("ferr_cleared", 8'h0B, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("pulse_count", pulses, exp_pulses);
    chk("idle_ctl_errs", idle_errs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
